vga_timing_recovery: RTL and testbench
======================================

Name: vga_timing_recovery

Overview:
- Sink-side counterpart to the team's VGA timing generator.
- Consumes active-low hsync/vsync plus a video-enable strobe, all sampled in the pixel-clock domain.
- Recovers per-pixel (x, y) coordinates and measures frame geometry (totals and active sizes).
- Declares lock after the geometry stays stable; used to check generated timing and to drive downstream pixel consumers from sync signals alone.

Parameters:
- LOCK_FRAMES, 2: consecutive matching frame snapshots needed for lock.
- TIMEOUT, 4096: cycles without an hsync falling edge before the block forces SEARCH.
- CW, 12: width of the measurement counters and registers.

Ports:
- i_clk  in  1  pixel clock.
- i_rstn  in  1  reset.
- i_hsync  in  1  horizontal sync, active-low.
- i_vsync  in  1  vertical sync, active-low.
- i_video  in  1  active-video strobe.
- o_video  out  1  i_video delayed 2 cycles; o_x and o_y are aligned to it.
- o_x  out  10  recovered column.
- o_y  out  10  recovered active-line index.
- o_frame_start  out  1  1-cycle pulse per detected vsync falling edge.
- o_h_total  out  CW  cycles per line, from the last locked reference.
- o_v_total  out  CW  lines per frame.
- o_h_active  out  CW  active pixels per line.
- o_v_active  out  CW  active lines per frame.
- o_locked  out  1  geometry stable.
- o_err  out  1  1-cycle pulse on loss of lock.

Behaviour:
- Reset: i_rstn is asynchronous, active-low; clock is i_clk. All outputs, counters, references and the FSM clear to 0 / SEARCH.
- Input pipeline: stage1 registers the inputs; stage2 holds the previous stage1 value. Edges are detected by comparing stage1 with stage2:
  - hfall = stage2 hsync high and stage1 hsync low.
  - vfall is defined the same way on vsync.
  - Video rise and fall are detected the same way.
- All outputs are registered from stage1, so they lag the inputs by 2 cycles.
- o_x: 0 on the first cycle o_video is high, then +1 per cycle while high. Returns to 0 while o_video is low. Wraps at 1023.
- o_y: 0 after vfall; +1 on each video falling edge. Wraps at 1023.
- Line counter hcnt:
  - Increments each cycle, saturating at 2^CW-1.
  - On hfall, latches into h_meas and reloads to 1, so the period equals the edge-to-edge distance.
- Per-line active count vcnt_line: counts video-high cycles. On video fall it is latched into ha_meas and cleared.
- Per-frame counters:
  - lines = number of hfalls.
  - alines = number of video falls.
  - Both saturate, and both clear on vfall after being snapshotted.
- Snapshot S = {h_meas, lines, ha_meas, alines}, taken at every vfall.
- FSM:
  - SEARCH: on vfall, go to MEASURE. Snapshot is discarded because the frame is partial.
  - MEASURE: on vfall, REF <= S and go to VERIFY with match=0.
  - VERIFY: on vfall, if S==REF then match+1; when match reaches LOCK_FRAMES, go to LOCKED and drive o_locked=1 the next cycle. If S!=REF, then REF <= S and match <= 0.
  - LOCKED: on vfall with S!=REF, pulse o_err, REF <= S, go to VERIFY. On any hfall with the new h_meas != REF.h_total, pulse o_err and go to VERIFY.
  - Any state: if hcnt reaches TIMEOUT, go to SEARCH. o_err pulses only if the FSM was in LOCKED.
- o_locked=1 only in LOCKED.
- o_*_total and o_*_active show REF, updated when REF loads.
- Simultaneous vfall and hfall: process the hfall count first. The line that ends at vfall is included in S.
- Reset mid-operation clears lock immediately. No o_err pulse is generated.

Test Plan:
- Default 640x480 generator (800x525) from reset: o_locked rises after the 4th vfall. Then o_h_total=800, o_v_total=525, o_h_active=640, o_v_active=480, and o_err stays 0.
- Locked steady state: on the last active pixel, o_x=639 and o_y=479. o_x=0 on each line's first active pixel. One o_frame_start per 420000 cycles.
- While locked, suppress one hsync pulse: o_err pulses once at the next hfall (h_meas=1600), o_locked drops, and lock is regained LOCK_FRAMES+1 frames after timing restores.
- Hold i_hsync high for 4096 cycles while locked: the FSM enters SEARCH, o_err pulses, and o_locked=0.
- Switch to 800-active/1056-total timing: lock recovers with o_h_total=1056 and o_h_active=800.
- Assert i_rstn low mid-frame while locked: all outputs read 0 asynchronously. After release, re-lock follows the same 4-vfall sequence.

Source files
------------

// File: rtl/vga_timing_recovery.sv
// Sink-side VGA timing recovery: rebuilds pixel coordinates from hsync/vsync/video
// and measures frame geometry, declaring lock once the geometry repeats.
module vga_timing_recovery #(
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 4096,
    parameter int CW          = 12
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic          i_video,
    output logic          o_video,
    output logic [9:0]    o_x,
    output logic [9:0]    o_y,
    output logic          o_frame_start,
    output logic [CW-1:0] o_h_total,
    output logic [CW-1:0] o_v_total,
    output logic [CW-1:0] o_h_active,
    output logic [CW-1:0] o_v_active,
    output logic          o_locked,
    output logic          o_err
);

    localparam logic [CW-1:0] CMAX = {CW{1'b1}};
    // A saturating counter cannot exceed CMAX, so a larger TIMEOUT fires at saturation.
    localparam logic [CW-1:0] TO_CNT = (TIMEOUT >= (1 << CW)) ? CMAX : CW'(TIMEOUT);
    localparam int MW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    logic hs1_q, vs1_q, vd1_q, hs2_q, vs2_q, vd2_q;
    logic [CW-1:0] hcnt_q, h_meas_q, vcnt_line_q, ha_meas_q, lines_q, alines_q;
    logic [CW-1:0] ref_h_q, ref_v_q, ref_ha_q, ref_va_q;
    logic [MW-1:0] match_q, match_d;
    state_t        state_q, state_d;
    logic          video_q, fs_q, err_q, err_d, ref_load;
    logic [9:0]    x_q, y_q;

    logic hfall, vfall, vidfall, timeout, snap_eq;
    logic [CW-1:0] snap_h, snap_lines, snap_ha, snap_al;

    assign hfall   = hs2_q & ~hs1_q;
    assign vfall   = vs2_q & ~vs1_q;
    assign vidfall = vd2_q & ~vd1_q;
    assign timeout = (hcnt_q >= TO_CNT);

    // Events landing on the vfall cycle still belong to the frame being closed.
    assign snap_h     = hfall   ? hcnt_q              : h_meas_q;
    assign snap_lines = hfall   ? sat_inc(lines_q)    : lines_q;
    assign snap_ha    = vidfall ? vcnt_line_q         : ha_meas_q;
    assign snap_al    = vidfall ? sat_inc(alines_q)   : alines_q;
    assign snap_eq    = (snap_h == ref_h_q) && (snap_lines == ref_v_q) &&
                        (snap_ha == ref_ha_q) && (snap_al == ref_va_q);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            vd1_q       <= 1'b0;
            hs2_q       <= 1'b0;
            vs2_q       <= 1'b0;
            vd2_q       <= 1'b0;
            hcnt_q      <= '0;
            h_meas_q    <= '0;
            vcnt_line_q <= '0;
            ha_meas_q   <= '0;
            lines_q     <= '0;
            alines_q    <= '0;
            video_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            fs_q        <= 1'b0;
        end else begin
            hs1_q       <= i_hsync;
            vs1_q       <= i_vsync;
            vd1_q       <= i_video;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            vd2_q       <= vd1_q;
            hcnt_q      <= hfall ? CW'(1) : sat_inc(hcnt_q);
            h_meas_q    <= snap_h;
            ha_meas_q   <= snap_ha;
            vcnt_line_q <= vidfall ? '0 : (vd1_q ? sat_inc(vcnt_line_q) : vcnt_line_q);
            lines_q     <= vfall ? '0 : snap_lines;
            alines_q    <= vfall ? '0 : snap_al;
            video_q     <= vd1_q;
            x_q         <= (vd1_q && vd2_q) ? x_q + 10'd1 : 10'd0;
            y_q         <= vfall ? 10'd0 : (vidfall ? y_q + 10'd1 : y_q);
            fs_q        <= vfall;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= SEARCH;
            match_q  <= '0;
            err_q    <= 1'b0;
            ref_h_q  <= '0;
            ref_v_q  <= '0;
            ref_ha_q <= '0;
            ref_va_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            err_q   <= err_d;
            if (ref_load) begin
                ref_h_q  <= snap_h;
                ref_v_q  <= snap_lines;
                ref_ha_q <= snap_ha;
                ref_va_q <= snap_al;
            end
        end
    end

    // Timeout outranks frame events; the first frame after SEARCH is always partial.
    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        ref_load = 1'b0;
        err_d    = 1'b0;
        if (timeout) begin
            state_d = SEARCH;
            match_d = '0;
            err_d   = (state_q == LOCKED);
        end else begin
            case (state_q)
                SEARCH: begin
                    if (vfall) state_d = MEASURE;
                end
                MEASURE: begin
                    if (vfall) begin
                        ref_load = 1'b1;
                        match_d  = '0;
                        state_d  = VERIFY;
                    end
                end
                VERIFY: begin
                    if (vfall) begin
                        if (snap_eq) begin
                            match_d = match_q + 1'b1;
                            if (match_d == MW'(LOCK_FRAMES)) state_d = LOCKED;
                        end else begin
                            ref_load = 1'b1;
                            match_d  = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (vfall) begin
                        if (!snap_eq) begin
                            err_d    = 1'b1;
                            ref_load = 1'b1;
                            match_d  = '0;
                            state_d  = VERIFY;
                        end
                    end else if (hfall && (hcnt_q != ref_h_q)) begin
                        err_d   = 1'b1;
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    assign o_video       = video_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_frame_start = fs_q;
    assign o_h_total     = ref_h_q;
    assign o_v_total     = ref_v_q;
    assign o_h_active    = ref_ha_q;
    assign o_v_active    = ref_va_q;
    assign o_locked      = (state_q == LOCKED);
    assign o_err         = err_q;

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Bench for vga_timing_recovery: a small-geometry sync generator drives the DUT,
// pixel coordinates go through a scoreboard queue, lock/geometry checked per phase.
module tb_vga_timing_recovery;

    localparam int TO = 64;
    localparam int LF = 2;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          hsync = 1'b1;
    logic          vsync = 1'b1;
    logic          video = 1'b0;
    logic          o_video, o_frame_start, o_locked, o_err;
    logic [9:0]    o_x, o_y;
    logic [CW-1:0] o_h_total, o_v_total, o_h_active, o_v_active;

    vga_timing_recovery #(.LOCK_FRAMES(LF), .TIMEOUT(TO), .CW(CW)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_hsync      (hsync),
        .i_vsync      (vsync),
        .i_video      (video),
        .o_video      (o_video),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_frame_start(o_frame_start),
        .o_h_total    (o_h_total),
        .o_v_total    (o_v_total),
        .o_h_active   (o_h_active),
        .o_v_active   (o_v_active),
        .o_locked     (o_locked),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    logic [19:0] exp_q[$];

    int g_htot, g_hact, g_vtot, g_vact, hs_start, hs_w;
    int hc = 0, vc = 0, skip_line = -1;
    int drv_vf = 0, err_cnt = 0, fs_cnt = 0, lock_vf = -1;
    bit prev_locked = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_geom(input int htot, input int hact, input int vtot, input int vact);
        g_htot   = htot;
        g_hact   = hact;
        g_vtot   = vtot;
        g_vact   = vact;
        hs_start = hact + 2 + int'($urandom_range(0, 1));
        hs_w     = 2 + int'($urandom_range(0, 1));
    endtask

    // Expected coordinates are simply the generator's column and active line.
    task automatic drive_cycle();
        @(negedge clk);
        video = (hc < g_hact) && (vc < g_vact);
        hsync = !((hc >= hs_start) && (hc < hs_start + hs_w) && (vc != skip_line));
        vsync = !((vc >= g_vact + 1) && (vc < g_vact + 3));
        if (video) exp_q.push_back({10'(vc), 10'(hc)});
        if (hc == 0 && vc == g_vact + 1) drv_vf++;
        hc++;
        if (hc == g_htot) begin
            hc = 0;
            vc++;
            if (vc == g_vtot) vc = 0;
        end
    endtask

    task automatic run_frames(input int n);
        repeat (n * g_htot * g_vtot) drive_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            hsync = 1'b1;
            vsync = 1'b1;
            video = 1'b0;
        end
    endtask

    task automatic check_geom(input string tag);
        check({tag, "_locked"},   int'(o_locked),   1);
        check({tag, "_h_total"},  int'(o_h_total),  g_htot);
        check({tag, "_v_total"},  int'(o_v_total),  g_vtot);
        check({tag, "_h_active"}, int'(o_h_active), g_hact);
        check({tag, "_v_active"}, int'(o_v_active), g_vact);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_video"},   int'(o_video),       0);
        check({tag, "_x"},       int'(o_x),           0);
        check({tag, "_y"},       int'(o_y),           0);
        check({tag, "_fstart"},  int'(o_frame_start), 0);
        check({tag, "_locked"},  int'(o_locked),      0);
        check({tag, "_err"},     int'(o_err),         0);
        check({tag, "_h_total"}, int'(o_h_total),     0);
        check({tag, "_v_total"}, int'(o_v_total),     0);
        check({tag, "_h_act"},   int'(o_h_active),    0);
        check({tag, "_v_act"},   int'(o_v_active),    0);
    endtask

    // Monitor: pops the scoreboard on every presented pixel, counts pulses.
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            prev_locked = 1'b0;
        end else begin
            if (o_video) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL pixel_unexpected: got x=%0d y=%0d with empty queue", o_x, o_y);
                end else begin
                    check("pixel_yx", int'({o_y, o_x}), int'(exp_q.pop_front()));
                end
            end
            if (o_err) err_cnt++;
            if (o_frame_start) fs_cnt++;
            if (o_locked && !prev_locked) lock_vf = drv_vf;
            prev_locked = o_locked;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vf_base, e0, f0;

        // Reset state
        idle(4);
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Initial lock on geometry A
        set_geom(20, 12, 10, 6);
        hc = 0; vc = 0;
        vf_base = drv_vf;
        lock_vf = -1;
        run_frames(6);
        check("init_lock_vfall", lock_vf - vf_base, 4);
        check("init_err_count", err_cnt, 0);
        check_geom("init");

        // Steady state: one frame_start per frame, no errors
        f0 = fs_cnt;
        e0 = err_cnt;
        run_frames(3);
        check("steady_fstart", fs_cnt - f0, 3);
        check("steady_err", err_cnt - e0, 0);
        check("steady_locked", int'(o_locked), 1);

        // Suppress one hsync pulse
        e0 = err_cnt;
        vf_base = drv_vf;
        lock_vf = -1;
        skip_line = int'($urandom_range(0, g_vact - 1));
        run_frames(1);
        skip_line = -1;
        check("glitch_err", err_cnt - e0, 1);
        check("glitch_unlocked", int'(o_locked), 0);
        run_frames(4);
        check("glitch_relock_vfall", lock_vf - vf_base, 4);
        check("glitch_err_total", err_cnt - e0, 1);
        check_geom("glitch");

        // hsync held high past the timeout
        e0 = err_cnt;
        repeat (TO + 16) begin
            @(negedge clk);
            hsync = 1'b1;
            vsync = 1'b1;
            video = 1'b0;
        end
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_unlocked", int'(o_locked), 0);
        vf_base = drv_vf;
        lock_vf = -1;
        run_frames(6);
        check("timeout_relock_vfall", lock_vf - vf_base, 4);
        check_geom("timeout");

        // Switch to geometry B
        set_geom(26, 16, 12, 7);
        hc = 0; vc = 0;
        run_frames(7);
        check_geom("geomB");

        // Mid-frame asynchronous reset while locked
        repeat ((g_htot * g_vtot) / 2 + int'($urandom_range(0, 9))) drive_cycle();
        check("prereset_locked", int'(o_locked), 1);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        idle(4);
        rstn = 1'b1;
        hc = 0; vc = 0;
        vf_base = drv_vf;
        lock_vf = -1;
        e0 = err_cnt;
        run_frames(6);
        check("rerst_lock_vfall", lock_vf - vf_base, 4);
        check("rerst_err", err_cnt - e0, 0);
        check_geom("rerst");

        idle(8);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
